// File: rtl/ysyx_22050019_seq_pkg.sv
// Shared encodings for the execution sequencer: state codes, error causes, AXI response.
package ysyx_22050019_seq_pkg;

   localparam logic [2:0] S_RST   = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   typedef enum logic [2:0] {
      ST_RST   = S_RST,
      ST_FETCH = S_FETCH,
      ST_EXEC  = S_EXEC,
      ST_MEM   = S_MEM,
      ST_WB    = S_WB,
      ST_HALT  = S_HALT,
      ST_ERR   = S_ERR
   } seq_state_e;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_IFU_RESP = 3'd1;
   localparam logic [2:0] ERR_LSU_RESP = 3'd2;
   localparam logic [2:0] ERR_DECODE   = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

   localparam logic [1:0] AXI_OKAY = 2'b00;

   // True for the states in which an instruction is in flight.
   function automatic logic is_active(input seq_state_e s);
      return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_MEM) || (s == ST_WB);
   endfunction

endpackage

// File: rtl/ysyx_22050019_exec_sequencer_wdog.sv
// Watchdog for the fetch/memory wait states: cleared while idle, counts while enabled,
// flags expiry in the LIMIT-th consecutive enabled cycle.
module ysyx_22050019_seq_wdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt;

   // Wait-cycle counter; holds once expired so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire_c = en && (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22050019_exec_sequencer.sv
// Single-issue multi-cycle sequencer: FETCH -> EXEC -> (MEM) -> WB, with terminal HALT/ERR.
// Optional fetch/memory watchdog enabled by YSYX_22050019_SEQ_TIMEOUT_EN.
module ysyx_22050019_exec_sequencer
   import ysyx_22050019_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned INSTRET_W      = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 if_start,
   input  logic                 if_done,
   input  logic [1:0]           if_resp,
   input  logic                 dec_is_load,
   input  logic                 dec_is_store,
   input  logic                 dec_is_ebreak,
   output logic                 lsu_start,
   input  logic                 lsu_done,
   input  logic [1:0]           lsu_resp,
   output logic                 pc_we,
   output logic                 reg_we_gate,
   output logic                 csr_we_gate,
   output logic                 commit,
   output logic [INSTRET_W-1:0] instret,
   output logic                 busy,
   output logic                 halted,
   output logic                 err,
   output logic [2:0]           err_cause
);

   seq_state_e state, state_nxt;
   logic [2:0] cause_nxt;
   logic       if_start_nxt, lsu_start_nxt, wb_nxt, retire_nxt, busy_nxt;
   logic       waiting_c, timeout_c;

   assign waiting_c = (state == ST_FETCH) || (state == ST_MEM);

`ifdef YSYX_22050019_SEQ_TIMEOUT_EN
   ysyx_22050019_seq_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!waiting_c),
      .en       (waiting_c),
      .expire_c (timeout_c)
   );
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign timeout_c      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RST;
      else        state <= state_nxt;
   end

   // Next-state, error cause and next-cycle output decode.
   always_comb begin
      state_nxt     = state;
      cause_nxt     = ERR_NONE;
      if_start_nxt  = 1'b0;
      lsu_start_nxt = 1'b0;
      wb_nxt        = 1'b0;
      retire_nxt    = 1'b0;
      busy_nxt      = 1'b0;

      case (state)
         ST_RST: state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (if_done) begin
               if (if_resp == AXI_OKAY) begin
                  state_nxt = ST_EXEC;
               end else begin
                  state_nxt = ST_ERR;
                  cause_nxt = ERR_IFU_RESP;
               end
            end else if (timeout_c) begin
               state_nxt = ST_ERR;
               cause_nxt = ERR_TIMEOUT;
            end
         end
         ST_EXEC: begin
            if (dec_is_load && dec_is_store) begin
               state_nxt = ST_ERR;
               cause_nxt = ERR_DECODE;
            end else if (dec_is_ebreak) begin
               state_nxt = ST_HALT;
            end else if (dec_is_load || dec_is_store) begin
               state_nxt = ST_MEM;
            end else begin
               state_nxt = ST_WB;
            end
         end
         ST_MEM: begin
            if (lsu_done) begin
               if (lsu_resp == AXI_OKAY) begin
                  state_nxt = ST_WB;
               end else begin
                  state_nxt = ST_ERR;
                  cause_nxt = ERR_LSU_RESP;
               end
            end else if (timeout_c) begin
               state_nxt = ST_ERR;
               cause_nxt = ERR_TIMEOUT;
            end
         end
         ST_WB:   state_nxt = ST_FETCH;
         default: state_nxt = state;
      endcase

      if_start_nxt  = (state_nxt == ST_FETCH) && (state != ST_FETCH);
      lsu_start_nxt = (state_nxt == ST_MEM) && (state != ST_MEM);
      wb_nxt        = (state_nxt == ST_WB);
      retire_nxt    = wb_nxt || ((state == ST_EXEC) && (state_nxt == ST_HALT));
      busy_nxt      = is_active(state_nxt);
   end

   // Registered outputs; reset clears everything including the retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_start    <= 1'b0;
         lsu_start   <= 1'b0;
         pc_we       <= 1'b0;
         reg_we_gate <= 1'b0;
         csr_we_gate <= 1'b0;
         commit      <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         err_cause   <= ERR_NONE;
         instret     <= '0;
      end else begin
         if_start    <= if_start_nxt;
         lsu_start   <= lsu_start_nxt;
         pc_we       <= wb_nxt;
         reg_we_gate <= wb_nxt;
         csr_we_gate <= wb_nxt;
         commit      <= retire_nxt;
         busy        <= busy_nxt;
         halted      <= halted | (state_nxt == ST_HALT);
         err         <= err | (state_nxt == ST_ERR);
         if ((state != ST_ERR) && (state_nxt == ST_ERR)) err_cause <= cause_nxt;
         if (retire_nxt) instret <= instret + INSTRET_W'(1);
      end
   end

endmodule

// File: doc/ysyx_22050019_exec_sequencer.md
Name: ysyx_22050019_exec_sequencer

Overview:
Multi-cycle controller that sequences the core datapath (IFU fetch, IDU/EXU, LSU, WBU/regs/CSR) so that exactly one instruction is in flight at a time. It issues start pulses to the IFU and LSU AXI-lite masters, waits for their completion handshakes through the shared arbiter/SRAM, then gates PC update, register write and CSR write in a single writeback cycle. It also provides a retired-instruction counter and error/halt status for the simulation harness.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting in FETCH or MEM before a timeout error (used only with the watchdog feature)
INSTRET_W, 64, width of the retired-instruction counter

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
if_start  output  1  one-cycle pulse; IFU issues an AR for the current pc
if_done  input  1  IFU read-data handshake complete (rvalid&rready)
if_resp  input  2  IFU read response, sampled with if_done; 0 = OKAY
dec_is_load  input  1  IDU: current instruction is a load
dec_is_store  input  1  IDU: current instruction is a store
dec_is_ebreak  input  1  IDU: current instruction is ebreak
lsu_start  output  1  one-cycle pulse; LSU starts its AR or AW/W transaction
lsu_done  input  1  LSU transaction complete (R or B handshake)
lsu_resp  input  2  LSU response, sampled with lsu_done; 0 = OKAY
pc_we  output  1  PC register update enable
reg_we_gate  output  1  ANDed with the decoded regfile write enable
csr_we_gate  output  1  ANDed with the decoded CSR write enable
commit  output  1  one-cycle pulse per retired instruction (difftest trigger)
instret  output  INSTRET_W  retired-instruction count
busy  output  1  high in FETCH, EXEC, MEM or WB
halted  output  1  sticky; ebreak retired
err  output  1  sticky error flag
err_cause  output  3  error code, valid while err=1

Behaviour:
- Reset (rst_n=0, async): state=RST. All outputs 0 (instret=0, err_cause=0).
- States: RST, FETCH, EXEC, MEM, WB, HALT, ERR. All outputs are registered or Moore-decoded. No combinational path from inputs to outputs.
- RST -> FETCH on the first clk edge with rst_n=1. if_start=1 in the first cycle of every FETCH visit only.
- FETCH: wait for if_done. if_done with if_resp==0 -> EXEC. if_done with if_resp!=0 -> ERR, cause 1.
- EXEC: one cycle; decode inputs are sampled only here.
  - load&store both set -> ERR, cause 4.
  - ebreak -> HALT. commit=1 on the transition edge, instret+1, halted=1. No pc_we.
  - load or store -> MEM. lsu_start=1 in the first MEM cycle.
  - otherwise -> WB.
- MEM: wait for lsu_done. lsu_resp==0 -> WB. lsu_resp!=0 -> ERR, cause 2.
- WB: one cycle with pc_we=reg_we_gate=csr_we_gate=commit=1. instret increments, wrapping at 2^INSTRET_W. Next state FETCH.
- Latency: if if_done arrives N cycles after if_start (N>=0, same cycle allowed), an ALU instruction takes N+3 cycles from if_start to the next if_start. A load/store with lsu_done M cycles after lsu_start takes N+M+4 cycles.
- if_done outside FETCH and lsu_done outside MEM are ignored; they cause no state change.
- A done arriving in the same cycle as its start pulse is accepted.
- HALT and ERR are terminal; only rst_n exits them. busy=0 in both, and all gates stay 0.
- Asserting rst_n mid-transaction aborts immediately. No gate or commit is issued. instret clears.

Optional Feature:
YSYX_22050019_SEQ_TIMEOUT_EN:
- Defined: a watchdog counter clears on entry to FETCH or MEM and increments each cycle in those states. If it reaches TIMEOUT_CYCLES without the matching done -> ERR, cause 5.
- Undefined: no counter; FETCH and MEM wait indefinitely. Cause 5 is never produced.

Decomposition:
- Package ysyx_22050019_seq_pkg holds:
  - state encoding localparams (3 bits)
  - error codes: ERR_NONE=0, ERR_IFU_RESP=1, ERR_LSU_RESP=2, ERR_DECODE=4, ERR_TIMEOUT=5
  - AXI response OKAY=2'b00
- One sub-module, ysyx_22050019_seq_wdog: parameterised clear/enable/expire counter, instantiated only under the macro.

Test Plan:
- ALU stream: if_done 2 cycles after each if_start, no load/store. Expect commit every 5 cycles; instret=10 after 10 instructions; if_start and pc_we never high together.
- Load: dec_is_load=1 in EXEC, lsu_done 3 cycles after lsu_start with resp 0. Expect a single WB with all gates high 1 cycle after lsu_done; total 9 cycles with N=2.
- Responses: if_resp=2'b10 -> err=1, err_cause=1, busy=0, no commit. Separately, lsu_resp=2'b11 on a store -> err_cause=2.
- ebreak after 3 ALU instructions -> halted=1, instret=4, pc_we stays 0. Further if_done pulses produce no change.
- Spurious and illegal inputs:
  - lsu_done pulsed during FETCH -> ignored.
  - load&store both set in EXEC -> err_cause=4.
  - rst_n dropped mid-MEM -> all outputs 0 asynchronously, before the next clk edge.
- With YSYX_22050019_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: withhold if_done -> err_cause=5 after 8 FETCH cycles. Without the macro, the same stimulus keeps busy=1 indefinitely.
